serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 64 ++++++
 tb/tb_serial_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+ci, one full-adder slice per clock, LSB first
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] ra, rb, rs;
   logic [WIDTH:0] rs_ext;
   logic [CW-1:0] cnt;
   logic carry, sum_bit, carry_n, accept, last;
   assign sum_bit = ra[0] ^ rb[0] ^ carry;
   assign carry_n = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
   assign rs_ext  = {sum_bit, rs};
   assign accept  = start && state != RUN;
   assign last    = cnt == CW'(WIDTH - 1);
   assign busy    = state == RUN;
   assign done    = state == DONE;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   // next state: a start in IDLE or DONE always wins, RUN ends on the last bit
   always_comb begin
      state_n = accept ? RUN : (state == RUN && last) ? DONE : state == DONE ? IDLE : state;
   end
   // datapath: latch operands on accept, shift one bit per RUN edge, publish result on the last bit
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ra    <= '0;
         rb    <= '0;
         rs    <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         s     <= '0;
         co    <= 1'b0;
      end else if (accept) begin
         ra    <= a;
         rb    <= b;
         carry <= ci;
         cnt   <= '0;
      end else if (state == RUN) begin
         ra    <= ra >> 1;
         rb    <= rb >> 1;
         carry <= carry_n;
         rs    <= rs_ext[WIDTH:1];
         cnt   <= cnt + 1'b1;
         if (last) begin
            s  <= rs_ext[WIDTH:1];
            co <= carry_n;
         end
      end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder at WIDTH 8, 3 and 1
module tb_serial_adder;
   logic clk = 1'b0, rst_n = 1'b0;
   logic start8 = 1'b0, ci8 = 1'b0, busy8, done8, co8;
   logic [7:0] a8 = '0, b8 = '0, s8;
   logic start3 = 1'b0, ci3 = 1'b0, busy3, done3, co3;
   logic [2:0] a3 = '0, b3 = '0, s3;
   logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0, busy1, done1, s1, co1;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
      .busy(busy8), .done(done8), .s(s8), .co(co8));
   serial_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .ci(ci3),
      .busy(busy3), .done(done3), .s(s3), .co(co3));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
      .busy(busy1), .done(done1), .s(s1), .co(co1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference for the 8-bit instance: an accepted request yields a+b+ci after 8 clocks
   logic m_busy, m_done, m_co;
   logic [7:0] m_s;
   logic [8:0] m_res;
   int m_left;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_s <= '0; m_co <= 1'b0; m_left <= 0; m_res <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               {m_co, m_s} <= m_res;
            end
            m_left <= m_left - 1;
         end else if (start8) begin
            m_busy <= 1'b1;
            m_left <= 8;
            m_res  <= 9'(a8) + 9'(b8) + 9'(ci8);
         end
      end

   always @(negedge clk) begin
      chk("busy8", 32'(busy8), 32'(m_busy));
      chk("done8", 32'(done8), 32'(m_done));
      chk("s8", 32'(s8), 32'(m_s));
      chk("co8", 32'(co8), 32'(m_co));
   end

   // 3-bit instance: results in issue order, one done every 4 cycles
   logic [3:0] q3[$];
   int gap3 = 0, n3 = 0;
   always @(negedge clk) begin
      gap3++;
      if (done3) begin
         if (q3.size() == 0) chk("spurious_done3", 32'(done3), 32'd0);
         else chk("sum3", 32'({co3, s3}), 32'(q3.pop_front()));
         if (n3 > 0) chk("spacing3", 32'(gap3), 32'd4);
         gap3 = 0;
         n3++;
      end
   end

   task automatic wait_done8();
      int n = 0;
      @(negedge clk);
      while (!done8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done8_timeout", 32'(done8), 32'd1);
   endtask

   task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
      @(posedge clk);
      #1 a8 = x; b8 = y; ci8 = c; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      wait_done8();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_s", 32'(s8), 32'd0);
      chk("rst_co", 32'(co8), 32'd0);
      rst_n = 1'b1;
      op8(8'h5A, 8'hA5, 1'b1);
      chk("t1_s", 32'(s8), 32'h00);
      chk("t1_co", 32'(co8), 32'd1);
      op8(8'hFF, 8'h01, 1'b0);
      chk("t2a_s", 32'(s8), 32'h00);
      chk("t2a_co", 32'(co8), 32'd1);
      op8(8'h12, 8'h34, 1'b0);
      chk("t2b_s", 32'(s8), 32'h46);
      chk("t2b_co", 32'(co8), 32'd0);
      // start held high, operands scrambled during RUN
      @(posedge clk);
      #1 a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
         @(negedge clk);
         if (i == 7) start8 = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      chk("t4_done", 32'(done8), 32'd1);
      chk("t4_s", 32'(s8), 32'h10);
      chk("t4_co", 32'(co8), 32'd0);
      // asynchronous reset in the middle of a run
      @(posedge clk);
      #1 a8 = 8'h33; b8 = 8'h44; ci8 = 1'b1; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy8), 32'd0);
      chk("arst_done", 32'(done8), 32'd0);
      chk("arst_s", 32'(s8), 32'd0);
      chk("arst_co", 32'(co8), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      op8(8'h80, 8'h80, 1'b0);
      chk("t5_s", 32'(s8), 32'h00);
      chk("t5_co", 32'(co8), 32'd1);
      for (int k = 0; k < 40; k++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      // exhaustive 3-bit, back-to-back through the DONE cycle
      @(posedge clk);
      #1 a3 = 3'd0; b3 = 3'd0; ci3 = 1'b0; start3 = 1'b1;
      q3.push_back(4'd0);
      for (int k = 0; k < 128; k++) begin
         @(posedge clk);
         #1;
         if (k < 127) begin
            a3 = 3'((k + 1) & 7);
            b3 = 3'(((k + 1) >> 3) & 7);
            ci3 = 1'(((k + 1) >> 6) & 1);
            q3.push_back(4'(a3) + 4'(b3) + 4'(ci3));
         end else start3 = 1'b0;
         repeat (3) @(posedge clk);
      end
      repeat (6) @(posedge clk);
      chk("count3", 32'(n3), 32'd128);
      // width 1: done two edges after the start edge
      @(posedge clk);
      #1 a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      chk("w1_busy", 32'(busy1), 32'd1);
      chk("w1_early", 32'(done1), 32'd0);
      @(negedge clk);
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_s", 32'(s1), 32'd1);
      chk("w1_co", 32'(co1), 32'd1);
      @(negedge clk);
      chk("w1_pulse", 32'(done1), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
